// File: rtl/rd_out_buffer.sv
// Small register FIFO that holds words captured from the RAM read port until
// the downstream consumer takes them. Head entry is read straight from the
// storage registers, so there is no path from push_data to head_data.
module rd_out_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (level == LVL_W'(DEPTH));
    assign head_valid = (level != '0);
    assign head_data  = mem[rd_ptr];

    // Storage, pointers and level; push and pop in the same cycle keep the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // The upstream credit logic must never let a word land in a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop))
                else $error("rd_out_buffer: capture into a full buffer");
        end
    end

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side stage behind the FIFO controller and its RAM. It issues pops on
// its own, tracks each pop through the RAM read latency with a valid-bit
// pipe, and only requests a pop when the output buffer is guaranteed to have
// room for that word when it arrives.
//
// Output handshake: a word moves when out_valid && out_ready in the same
// cycle. While out_valid is high and out_ready is low, out_valid and out_data
// hold; out_valid only falls after a handshake.
module fifo_read_stream #(
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_empty,
    output logic                               fifo_read_req,
    input  logic [WIDTH-1:0]                   ram_read_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_level
);

    // Wide enough for buffered + in-flight words and for BUF_DEPTH + 1.
    localparam int SUM_W = $clog2(BUF_DEPTH + RD_LATENCY + 2);

    logic [RD_LATENCY-1:0] vpipe;
    logic [SUM_W-1:0]      inflight;
    logic                  pop_accepted;
    logic                  pop_out;
    logic                  capture;
    logic                  credit_ok;

    assign pop_out      = out_valid && out_ready;
    assign capture      = vpipe[RD_LATENCY-1];
    assign pop_accepted = fifo_read_req && !fifo_empty;

    // Count pops whose data has not reached the buffer yet.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SUM_W'(vpipe[i]);
        end
    end

    // Words already owed to the buffer, less the one leaving this cycle,
    // must leave a free slot for the new pop.
    assign credit_ok = (SUM_W'(buf_level) + inflight) <
                       (SUM_W'(BUF_DEPTH) + SUM_W'(pop_out));

    assign fifo_read_req = !rst && !fifo_empty && credit_ok;

    // Valid-bit pipe: the top bit marks the cycle ram_read_data carries a popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= pop_accepted;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    rd_out_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .push_data  (ram_read_data),
        .pop        (pop_out),
        .head_data  (out_data),
        .head_valid (out_valid),
        .level      (buf_level)
    );

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream. A behavioural FIFO+RAM drives two instances
// (defaults, and RD_LATENCY=3/BUF_DEPTH=4); one is active at a time, the
// other is held idle. Expected level, valid, request and data come from a
// queue of popped words stamped with their pop cycle.
module tb_fifo_read_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       empty_a, req_a, valid_a, ready_a;
    logic [7:0] ram_a, data_a;
    logic [1:0] lvl_a;
    logic       empty_b, req_b, valid_b, ready_b;
    logic [7:0] ram_b, data_b;
    logic [2:0] lvl_b;

    fifo_read_stream #(.WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_read_req(req_a),
        .ram_read_data(ram_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(data_a), .buf_level(lvl_a)
    );

    fifo_read_stream #(.WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_read_req(req_b),
        .ram_read_data(ram_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .buf_level(lvl_b)
    );

    int total = 0;
    int bad   = 0;

    int sel, lat, depth, cyc, ready_mode, consumed, gaps;
    bit seen_valid, prev_stall;
    logic [7:0] prev_data;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic [7:0] dl_data[$];
    int         dl_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive inputs for the cycle that just started.
    task automatic drive();
        logic [7:0] rd;
        logic       r;
        logic       e;
        rd = 8'($urandom);
        if (dl_cyc.size() > 0 && dl_cyc[0] == cyc) begin
            rd = dl_data.pop_front();
            void'(dl_cyc.pop_front());
        end
        r = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        e = (src_q.size() == 0);
        if (sel == 0) begin
            empty_a = e; ready_a = r; ram_a = rd;
            empty_b = 1'b1; ready_b = 1'b1; ram_b = 8'($urandom);
        end else begin
            empty_b = e; ready_b = r; ram_b = rd;
            empty_a = 1'b1; ready_a = 1'b1; ram_a = 8'($urandom);
        end
    endtask

    // One clock: check at the negedge against the model, then advance.
    task automatic step();
        logic       v, q, e, r;
        logic [7:0] d;
        int         lv, lvl_m, exp_pop;
        logic [7:0] w;
        @(negedge clk);
        v  = sel ? valid_b : valid_a;
        q  = sel ? req_b   : req_a;
        e  = sel ? empty_b : empty_a;
        r  = sel ? ready_b : ready_a;
        d  = sel ? data_b  : data_a;
        lv = sel ? int'(lvl_b) : int'(lvl_a);
        if (rst) begin
            check("req_in_reset", 32'(q), 0);
            prev_stall = 1'b0;
        end else begin
            lvl_m = 0;
            foreach (acc_q[i]) if (acc_q[i] + lat < cyc) lvl_m++;
            exp_pop = (lvl_m > 0 && r) ? 1 : 0;
            check("buf_level", lv, lvl_m);
            check("out_valid", 32'(v), (lvl_m > 0) ? 1 : 0);
            check("fifo_read_req", 32'(q), (!e && (exp_q.size() - exp_pop < depth)) ? 1 : 0);
            if (prev_stall) begin
                check("stall_valid", 32'(v), 1);
                check("stall_data", 32'(d), 32'(prev_data));
            end
            if (lvl_m > 0) check("out_data", 32'(d), 32'(exp_q[0]));
            if (v && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", exp_q.size(), 1);
                end else begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    consumed++;
                end
            end
            if (v) seen_valid = 1'b1;
            else if (seen_valid && (exp_q.size() > 0 || src_q.size() > 0)) gaps++;
            prev_stall = v && !r;
            prev_data  = d;
            if (q && !e) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
                acc_q.push_back(cyc);
                dl_data.push_back(w);
                dl_cyc.push_back(cyc + lat);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    // Reset clears the FIFO contents and expectations; late RAM data stays queued.
    task automatic do_reset(input int n);
        rst = 1'b1;
        src_q.delete();
        exp_q.delete();
        acc_q.delete();
        seen_valid = 1'b0;
        prev_stall = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    endtask

    initial begin
        rst = 1'b1; sel = 0; lat = 1; depth = 2; cyc = 0; ready_mode = 1;
        consumed = 0; gaps = 0; seen_valid = 1'b0; prev_stall = 1'b0; prev_data = '0;
        drive();
        do_reset(2);
        check("reset_data", 32'(data_a), 0);

        // Idle with an empty FIFO: no requests, nothing buffered.
        for (int i = 0; i < 10; i++) step();

        // Three known words with the consumer always ready.
        consumed = 0;
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        for (int i = 0; i < 8; i++) step();
        check("three_consumed", consumed, 3);

        // Blocked consumer: exactly two pops, then release and drain 16 in order.
        consumed = 0;
        ready_mode = 0;
        load(16);
        for (int i = 0; i < 10; i++) step();
        check("blocked_level", 32'(lvl_a), 2);
        check("blocked_src_left", src_q.size(), 14);
        check("blocked_req", 32'(req_a), 0);
        ready_mode = 1;
        step();
        gaps = 0;
        for (int i = 0; i < 60 && consumed < 16; i++) step();
        check("drain_consumed", consumed, 16);
        check("drain_gaps", gaps, 0);

        // Random back-pressure over 256 words.
        consumed = 0;
        ready_mode = 2;
        load(256);
        for (int i = 0; i < 3000 && consumed < 256; i++) step();
        check("random_consumed", consumed, 256);

        // Longer RAM latency with deeper buffer: one word per cycle once primed.
        sel = 1; lat = 3; depth = 4; ready_mode = 1;
        do_reset(2);
        consumed = 0;
        gaps = 0;
        load(20);
        for (int i = 0; i < 100 && consumed < 20; i++) step();
        check("lat3_consumed", consumed, 20);
        check("lat3_gaps", gaps, 0);

        // Reset with one word buffered and one in flight.
        sel = 0; lat = 1; depth = 2; ready_mode = 0;
        do_reset(2);
        load(5);
        for (int i = 0; i < 10 && !(lvl_a == 2'd1 && exp_q.size() == 2); i++) step();
        check("pre_reset_level", 32'(lvl_a), 1);
        check("pre_reset_owed", exp_q.size(), 2);
        do_reset(1);
        check("post_reset_valid", 32'(valid_a), 0);
        check("post_reset_level", 32'(lvl_a), 0);
        for (int i = 0; i < 4; i++) step();
        check("late_data_level", 32'(lvl_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
